// File: rtl/defs.sv
// defs: shared core types.
// op_t encodes the execute-stage operation.
package defs;

  typedef enum logic [3:0] {
    NO_OP,
    ADD,
    SUB,
    SLL,
    SRL,
    SRA,
    LT,
    LTU,
    XOR,
    OR,
    AND,
    EQ,
    NEQ,
    GE,
    GEU
  } op_t;

endpackage

// File: rtl/alu.sv
// alu: execute-stage arithmetic unit with registered result and condition.
// Define ALU_SERIAL_SHIFT_EN for a one-bit-per-cycle shifter with busy.
module alu
  import defs::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_noop,
  input  op_t                in_op,
  input  logic signed [31:0] in_src1,
  input  logic signed [31:0] in_src2,
  output logic               out_busy,
  output logic               out_noop,
  output logic signed [31:0] out_result,
  output logic               out_cond
);

  logic        [4:0]  shamt;
  logic               bubble;
  logic               is_shift;
  logic signed [31:0] res_c;
  logic               cond_c;

  logic               noop_q, noop_d;
  logic signed [31:0] result_q, result_d;
  logic               cond_q, cond_d;

  assign shamt    = in_src2[4:0];
  assign bubble   = in_noop || (in_op == NO_OP);
  assign is_shift = (in_op == SLL) || (in_op == SRL) || (in_op == SRA);

  // Single-cycle result and condition for the op at the input.
  always_comb begin
    res_c  = '0;
    cond_c = 1'b0;
    case (in_op)
      ADD: res_c = in_src1 + in_src2;
      SUB: res_c = in_src1 - in_src2;
      XOR: res_c = in_src1 ^ in_src2;
      OR:  res_c = in_src1 | in_src2;
      AND: res_c = in_src1 & in_src2;
`ifdef ALU_SERIAL_SHIFT_EN
      SLL, SRL, SRA: res_c = in_src1;
`else
      SLL: res_c = in_src1 << shamt;
      SRL: res_c = in_src1 >> shamt;
      SRA: res_c = in_src1 >>> shamt;
`endif
      LT:  cond_c = in_src1 < in_src2;
      LTU: cond_c = $unsigned(in_src1) < $unsigned(in_src2);
      GE:  cond_c = in_src1 >= in_src2;
      GEU: cond_c = $unsigned(in_src1) >= $unsigned(in_src2);
      EQ:  cond_c = in_src1 == in_src2;
      NEQ: cond_c = in_src1 != in_src2;
      default: ;
    endcase
    res_c = res_c | {31'b0, cond_c};
  end

`ifdef ALU_SERIAL_SHIFT_EN

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d, acc_sh;
  logic [4:0]  cnt_q, cnt_d;
  op_t         sop_q, sop_d;

  // One-bit step of the latched shift.
  always_comb begin
    acc_sh = {acc_q[30:0], 1'b0};
    if (sop_q == SRL)
      acc_sh = {1'b0, acc_q[31:1]};
    else if (sop_q == SRA)
      acc_sh = {acc_q[31], acc_q[31:1]};
  end

  // Accept, start serial shifts, and publish when the count runs out.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    noop_d   = noop_q;
    result_d = result_q;
    cond_d   = cond_q;
    case (state_q)
      IDLE: begin
        if (bubble) begin
          noop_d = 1'b1;
        end else if (is_shift && shamt != 5'd0) begin
          acc_d   = in_src1;
          cnt_d   = shamt;
          sop_d   = in_op;
          noop_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          noop_d   = 1'b0;
          result_d = res_c;
          cond_d   = cond_c;
        end
      end
      SHIFT: begin
        acc_d = acc_sh;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          noop_d   = 1'b0;
          result_d = acc_sh;
          cond_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift engine state; reset drops any in-flight shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sop_q   <= NO_OP;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
    end
  end

  assign out_busy = (state_q == SHIFT);

`else

  // Every non-bubble input publishes on the next edge.
  always_comb begin
    noop_d   = 1'b1;
    result_d = result_q;
    cond_d   = cond_q;
    if (!bubble) begin
      noop_d   = 1'b0;
      result_d = res_c;
      cond_d   = cond_c;
    end
  end

  assign out_busy = 1'b0;

`endif

  // Output registers toward memory/writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noop_q   <= 1'b1;
      result_q <= '0;
      cond_q   <= 1'b0;
    end else begin
      noop_q   <= noop_d;
      result_q <= result_d;
      cond_q   <= cond_d;
    end
  end

  assign out_noop   = noop_q;
  assign out_result = result_q;
  assign out_cond   = cond_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed checks of the execute-stage alu.
// Expected timing follows ALU_SERIAL_SHIFT_EN when defined.
module tb_alu;
  import defs::*;

  logic               clk;
  logic               rst;
  logic               in_noop;
  op_t                in_op;
  logic signed [31:0] in_src1;
  logic signed [31:0] in_src2;
  logic               out_busy;
  logic               out_noop;
  logic signed [31:0] out_result;
  logic               out_cond;

  int errs;
  int checks;
  int lat;
  int extra;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .in_noop   (in_noop),
    .in_op     (in_op),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .out_busy  (out_busy),
    .out_noop  (out_noop),
    .out_result(out_result),
    .out_cond  (out_cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input op_t op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic nop);
    in_op   = op;
    in_src1 = a;
    in_src2 = b;
    in_noop = nop;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    errs   = 0;
    checks = 0;
    rst    = 1'b0;
    drive(NO_OP, 32'h0, 32'h0, 1'b1);

    // async reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_noop", 32'(out_noop), 32'd1);
    chk("rst_result", out_result, 32'h0);
    chk("rst_cond", 32'(out_cond), 32'd0);
    chk("rst_busy", 32'(out_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    drive(ADD, 32'h7FFFFFFF, 32'h1, 1'b0);
    tick();
    chk("add_ovf", out_result, 32'h80000000);
    chk("add_noop", 32'(out_noop), 32'd0);

    drive(SUB, 32'h0, 32'h1, 1'b0);
    tick();
    chk("sub_wrap", out_result, 32'hFFFFFFFF);

    drive(ADD, 32'd1, 32'd2, 1'b0);
    tick();
    chk("b2b_add1", out_result, 32'd3);
    drive(ADD, 32'd10, 32'd20, 1'b0);
    tick();
    chk("b2b_add2", out_result, 32'd30);
    chk("b2b_noop", 32'(out_noop), 32'd0);

    drive(ADD, 32'd5, 32'd5, 1'b1);
    tick();
    chk("bub_noop", 32'(out_noop), 32'd1);
    chk("bub_hold", out_result, 32'd30);
    drive(NO_OP, 32'd7, 32'd7, 1'b0);
    tick();
    chk("noop_op", 32'(out_noop), 32'd1);
    chk("noop_hold", out_result, 32'd30);

    drive(LT, 32'hFFFFFFFF, 32'd1, 1'b0);
    tick();
    chk("lt_cond", 32'(out_cond), 32'd1);
    chk("lt_res", out_result, 32'd1);
    drive(LTU, 32'hFFFFFFFF, 32'd1, 1'b0);
    tick();
    chk("ltu_cond", 32'(out_cond), 32'd0);
    chk("ltu_res", out_result, 32'd0);
    drive(GEU, 32'd5, 32'd5, 1'b0);
    tick();
    chk("geu_cond", 32'(out_cond), 32'd1);
    drive(NEQ, 32'd3, 32'd3, 1'b0);
    tick();
    chk("neq_cond", 32'(out_cond), 32'd0);
    drive(GE, 32'hFFFFFFFE, 32'd1, 1'b0);
    tick();
    chk("ge_cond", 32'(out_cond), 32'd0);
    drive(EQ, 32'd3, 32'd3, 1'b0);
    tick();
    chk("eq_cond", 32'(out_cond), 32'd1);

    drive(XOR, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    tick();
    chk("xor_res", out_result, 32'h0FF00FF0);
    chk("xor_cond", 32'(out_cond), 32'd0);
    drive(OR, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    tick();
    chk("or_res", out_result, 32'hFFF0FFF0);
    drive(AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    tick();
    chk("and_res", out_result, 32'hF000F000);

    drive(SRA, 32'h80000000, 32'h00000024, 1'b0);
    tick();
`ifdef ALU_SERIAL_SHIFT_EN
    chk("sra_busy0", 32'(out_busy), 32'd1);
    chk("sra_noop0", 32'(out_noop), 32'd1);
    drive(ADD, 32'd1, 32'd1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("sra_busy", 32'(out_busy), 32'd1);
      chk("sra_noop", 32'(out_noop), 32'd1);
    end
    tick();
    chk("sra_done_busy", 32'(out_busy), 32'd0);
`else
    chk("sra_busy", 32'(out_busy), 32'd0);
    drive(ADD, 32'd1, 32'd1, 1'b0);
`endif
    chk("sra_res", out_result, 32'hF8000000);
    chk("sra_done_noop", 32'(out_noop), 32'd0);
    chk("sra_cond", 32'(out_cond), 32'd0);
    tick();
    chk("after_sra_add", out_result, 32'd2);
    chk("after_sra_noop", 32'(out_noop), 32'd0);

    drive(SLL, 32'd1, 32'd31, 1'b0);
    tick();
    lat = 0;
    while (out_noop && lat < 40) begin
      tick();
      lat++;
    end
    drive(NO_OP, 32'd0, 32'd0, 1'b1);
    chk("sll31_res", out_result, 32'h80000000);
`ifdef ALU_SERIAL_SHIFT_EN
    chk("sll31_lat", 32'(lat), 32'd31);
`else
    chk("sll31_lat", 32'(lat), 32'd0);
`endif

    drive(SRL, 32'hDEADBEEF, 32'h00000020, 1'b0);
    tick();
    chk("srl0_res", out_result, 32'hDEADBEEF);
    chk("srl0_noop", 32'(out_noop), 32'd0);
    chk("srl0_busy", 32'(out_busy), 32'd0);

    drive(SRL, 32'hFFFFFFFF, 32'd20, 1'b0);
    tick();
    drive(ADD, 32'd4, 32'd5, 1'b0);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_noop", 32'(out_noop), 32'd1);
    chk("midrst_res", out_result, 32'h0);
    chk("midrst_cond", 32'(out_cond), 32'd0);
    chk("midrst_busy", 32'(out_busy), 32'd0);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_add", out_result, 32'd9);
    chk("post_rst_noop", 32'(out_noop), 32'd0);
    drive(NO_OP, 32'd0, 32'd0, 1'b1);
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (!out_noop) extra++;
    end
    chk("no_stale_shift", 32'(extra), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
